// File: rtl/pong_ball.sv
// Pong ball engine: moves a square ball once per animation tick, bounces off walls
// and the paddle top, flags floor misses and re-serves after a hold-off.
module pong_ball #(
  parameter int B_SIZE      = 8,
  parameter int SPEED       = 2,
  parameter int IX          = 320,
  parameter int IY          = 120,
  parameter int D_WIDTH     = 640,
  parameter int D_HEIGHT    = 480,
  parameter int SERVE_DELAY = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic [11:0] i_pad_x1,
  input  logic [11:0] i_pad_x2,
  input  logic [11:0] i_pad_y1,
  input  logic [11:0] i_pad_y2,
  output logic [11:0] o_x1,
  output logic [11:0] o_x2,
  output logic [11:0] o_y1,
  output logic [11:0] o_y2,
  output logic        o_hit,
  output logic        o_miss,
  output logic [7:0]  o_score,
  output logic [1:0]  o_state
);

  localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);

  localparam logic [12:0] BS13    = 13'(B_SIZE);
  localparam logic [12:0] SP13    = 13'(SPEED);
  localparam logic [12:0] X_LIM   = 13'(D_WIDTH - 1);
  localparam logic [12:0] Y_LIM   = 13'(D_HEIGHT - 1);
  localparam logic [11:0] BS12    = 12'(B_SIZE);
  localparam logic [11:0] SP12    = 12'(SPEED);
  localparam logic [11:0] X_RIGHT = 12'(D_WIDTH - 1 - B_SIZE);
  localparam logic [11:0] Y_FLOOR = 12'(D_HEIGHT - 1 - B_SIZE);
  localparam logic [11:0] IX12    = 12'(IX);
  localparam logic [11:0] IY12    = 12'(IY);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

  state_t             state;
  logic [11:0]        x, y;
  logic               dx, dy;
  logic [CNT_W-1:0]   cnt;
  logic               hit, miss;
  logic [7:0]         score;

  logic [12:0]        x13, y13;
  logic [11:0]        x_nx, y_nx;
  logic               dx_nx, dy_nx;
  logic               pad_hit, floor_hit;
  logic               tick;
  logic               unused_pad_y2;

  // Bottom edge of the paddle plays no part in collision.
  assign unused_pad_y2 = ^i_pad_y2;

  assign tick = i_ani_stb && i_animate;
  assign x13  = {1'b0, x};
  assign y13  = {1'b0, y};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One play step; both axes resolve independently so a corner bounces both.
  always_comb begin
    x_nx      = x;
    dx_nx     = dx;
    y_nx      = y;
    dy_nx     = dy;
    floor_hit = 1'b0;
    pad_hit   = (y13 + BS13 <= {1'b0, i_pad_y1}) &&
                (y13 + BS13 + SP13 >= {1'b0, i_pad_y1}) &&
                (x13 + BS13 >= {1'b0, i_pad_x1}) &&
                (x13 <= {1'b0, i_pad_x2} + BS13);
    if (dx) begin
      if (x13 + BS13 + SP13 >= X_LIM) begin
        x_nx  = X_RIGHT;
        dx_nx = 1'b0;
      end else begin
        x_nx = x + SP12;
      end
    end else if (x13 < BS13 + SP13) begin
      x_nx  = BS12;
      dx_nx = 1'b1;
    end else begin
      x_nx = x - SP12;
    end
    if (!dy) begin
      if (y13 < BS13 + SP13) begin
        y_nx  = BS12;
        dy_nx = 1'b1;
      end else begin
        y_nx = y - SP12;
      end
    end else if (pad_hit) begin
      y_nx  = i_pad_y1 - BS12;
      dy_nx = 1'b0;
    end else if (y13 + BS13 + SP13 >= Y_LIM) begin
      y_nx      = Y_FLOOR;
      floor_hit = 1'b1;
    end else begin
      y_nx = y + SP12;
    end
  end

  // Serve tick that expires the hold-off also performs the first play step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= SERVE;
      x     <= IX12;
      y     <= IY12;
      dx    <= 1'b1;
      dy    <= 1'b1;
      cnt   <= CNT_W'(SERVE_DELAY);
      hit   <= 1'b0;
      miss  <= 1'b0;
      score <= 8'd0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (tick) begin
        case (state)
          SERVE, PLAY: begin
            if (state == SERVE && cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= floor_hit ? MISS : PLAY;
              x     <= x_nx;
              y     <= y_nx;
              dx    <= dx_nx;
              dy    <= dy_nx;
              if (dy && pad_hit) begin
                hit   <= 1'b1;
                score <= sat_inc(score);
              end
              miss <= floor_hit;
            end
          end
          MISS: begin
            state <= SERVE;
            x     <= IX12;
            y     <= IY12;
            dx    <= ~dx;
            dy    <= 1'b1;
            cnt   <= CNT_W'(SERVE_DELAY);
          end
          default: state <= SERVE;
        endcase
      end
    end
  end

  assign o_x1    = x - BS12;
  assign o_x2    = x + BS12;
  assign o_y1    = y - BS12;
  assign o_y2    = y + BS12;
  assign o_hit   = hit;
  assign o_miss  = miss;
  assign o_score = score;
  assign o_state = state;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: a default-size instance for serve/wall/miss/hit/reset
// and a small square-field instance for corner bounces and score saturation.
module tb_pong_ball;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stb = 1'b0, animate = 1'b1, stb_b = 1'b0, animate_b = 1'b1;
  logic [11:0] pad_x1 = 12'd20, pad_x2 = 12'd180, pad_y1 = 12'd420, pad_y2 = 12'd430;
  logic [11:0] bpad_x1 = 12'd0, bpad_x2 = 12'd100, bpad_y1 = 12'd40, bpad_y2 = 12'd45;

  logic [11:0] a_x1, a_x2, a_y1, a_y2, b_x1, b_x2, b_y1, b_y2;
  logic        a_hit, a_miss, b_hit, b_miss;
  logic [7:0]  a_score, b_score;
  logic [1:0]  a_state, b_state;

  int n_cmp = 0;
  int n_err = 0;

  pong_ball dut_a (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(animate),
    .i_pad_x1(pad_x1), .i_pad_x2(pad_x2), .i_pad_y1(pad_y1), .i_pad_y2(pad_y2),
    .o_x1(a_x1), .o_x2(a_x2), .o_y1(a_y1), .o_y2(a_y2),
    .o_hit(a_hit), .o_miss(a_miss), .o_score(a_score), .o_state(a_state)
  );

  pong_ball #(
    .B_SIZE(8), .SPEED(2), .IX(20), .IY(20), .D_WIDTH(41), .D_HEIGHT(41), .SERVE_DELAY(0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb_b), .i_animate(animate_b),
    .i_pad_x1(bpad_x1), .i_pad_x2(bpad_x2), .i_pad_y1(bpad_y1), .i_pad_y2(bpad_y2),
    .o_x1(b_x1), .o_x2(b_x2), .o_y1(b_y1), .o_y2(b_y2),
    .o_hit(b_hit), .o_miss(b_miss), .o_score(b_score), .o_state(b_state)
  );

  task automatic tick_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); stb = 1'b1;
      @(negedge clk); stb = 1'b0;
    end
  endtask

  task automatic tick_b(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); stb_b = 1'b1;
      @(negedge clk); stb_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (a_x1 !== 12'd312) begin n_err++; $display("FAIL reset_x1 got %0d want 312", a_x1); end
    n_cmp++; if (a_x2 !== 12'd328) begin n_err++; $display("FAIL reset_x2 got %0d want 328", a_x2); end
    n_cmp++; if (a_y1 !== 12'd112) begin n_err++; $display("FAIL reset_y1 got %0d want 112", a_y1); end
    n_cmp++; if (a_y2 !== 12'd128) begin n_err++; $display("FAIL reset_y2 got %0d want 128", a_y2); end
    n_cmp++; if (a_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", a_state); end
    n_cmp++; if (a_hit !== 1'b0 || a_miss !== 1'b0) begin n_err++; $display("FAIL reset_pulses got %b%b want 00", a_hit, a_miss); end
    n_cmp++; if (a_score !== 8'd0) begin n_err++; $display("FAIL reset_score got %0d want 0", a_score); end
  endtask

  task automatic test_serve_freeze();
    for (int i = 0; i < 30; i++) begin
      tick_a(1);
      n_cmp++; if (a_state !== 2'd0 || a_x1 !== 12'd312 || a_y1 !== 12'd112) begin
        n_err++; $display("FAIL serve_hold tick %0d got st=%0d x1=%0d y1=%0d want 0/312/112", i + 1, a_state, a_x1, a_y1);
      end
    end
    animate = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick_a(1);
      n_cmp++; if (a_state !== 2'd0 || a_x1 !== 12'd312 || a_y1 !== 12'd112 || a_hit !== 1'b0 || a_miss !== 1'b0) begin
        n_err++; $display("FAIL freeze frame %0d got st=%0d x1=%0d y1=%0d h=%b m=%b", i, a_state, a_x1, a_y1, a_hit, a_miss);
      end
    end
    animate = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick_a(1);
      n_cmp++; if (a_state !== 2'd0) begin n_err++; $display("FAIL serve_after_freeze tick %0d got st=%0d want 0", i + 31, a_state); end
    end
    tick_a(1);
    n_cmp++; if (a_state !== 2'd1) begin n_err++; $display("FAIL serve_to_play state got %0d want 1", a_state); end
    n_cmp++; if (a_x1 !== 12'd314 || a_y1 !== 12'd114) begin n_err++; $display("FAIL first_move got x1=%0d y1=%0d want 314/114", a_x1, a_y1); end
  endtask

  task automatic test_right_wall();
    tick_a(154);
    n_cmp++; if (a_x1 !== 12'd622 || a_y1 !== 12'd422) begin n_err++; $display("FAIL pre_wall got x1=%0d y1=%0d want 622/422", a_x1, a_y1); end
    tick_a(1);
    n_cmp++; if (a_x1 !== 12'd623 || a_x2 !== 12'd639 || a_y1 !== 12'd424) begin
      n_err++; $display("FAIL wall_clamp got x1=%0d x2=%0d y1=%0d want 623/639/424", a_x1, a_x2, a_y1);
    end
    tick_a(1);
    n_cmp++; if (a_x1 !== 12'd621 || a_y1 !== 12'd426) begin n_err++; $display("FAIL wall_return got x1=%0d y1=%0d want 621/426", a_x1, a_y1); end
  endtask

  task automatic test_floor_miss();
    tick_a(18);
    n_cmp++; if (a_x1 !== 12'd585 || a_y1 !== 12'd462 || a_state !== 2'd1 || a_miss !== 1'b0) begin
      n_err++; $display("FAIL pre_floor got x1=%0d y1=%0d st=%0d m=%b want 585/462/1/0", a_x1, a_y1, a_state, a_miss);
    end
    tick_a(1);
    n_cmp++; if (a_y1 !== 12'd463 || a_y2 !== 12'd479 || a_x1 !== 12'd583) begin
      n_err++; $display("FAIL floor_pos got x1=%0d y1=%0d y2=%0d want 583/463/479", a_x1, a_y1, a_y2);
    end
    n_cmp++; if (a_miss !== 1'b1 || a_hit !== 1'b0 || a_state !== 2'd2) begin
      n_err++; $display("FAIL floor_miss got m=%b h=%b st=%0d want 1/0/2", a_miss, a_hit, a_state);
    end
    @(negedge clk);
    n_cmp++; if (a_miss !== 1'b0) begin n_err++; $display("FAIL miss_width got %b want 0", a_miss); end
    animate = 1'b0;
    tick_a(1);
    animate = 1'b1;
    n_cmp++; if (a_state !== 2'd2 || a_y1 !== 12'd463) begin n_err++; $display("FAIL miss_frozen got st=%0d y1=%0d want 2/463", a_state, a_y1); end
    tick_a(1);
    n_cmp++; if (a_state !== 2'd0 || a_x1 !== 12'd312 || a_y1 !== 12'd112) begin
      n_err++; $display("FAIL reserve got st=%0d x1=%0d y1=%0d want 0/312/112", a_state, a_x1, a_y1);
    end
  endtask

  task automatic test_paddle_hit();
    pad_x1 = 12'd560;
    pad_x2 = 12'd640;
    tick_a(61);
    n_cmp++; if (a_state !== 2'd1 || a_x1 !== 12'd314 || a_y1 !== 12'd114) begin
      n_err++; $display("FAIL serve_dir got st=%0d x1=%0d y1=%0d want 1/314/114", a_state, a_x1, a_y1);
    end
    tick_a(144);
    n_cmp++; if (a_x1 !== 12'd602 || a_y1 !== 12'd402 || a_hit !== 1'b0) begin
      n_err++; $display("FAIL pre_hit got x1=%0d y1=%0d h=%b want 602/402/0", a_x1, a_y1, a_hit);
    end
    tick_a(1);
    n_cmp++; if (a_y1 !== 12'd404 || a_x1 !== 12'd604) begin n_err++; $display("FAIL hit_pos got x1=%0d y1=%0d want 604/404", a_x1, a_y1); end
    n_cmp++; if (a_hit !== 1'b1 || a_score !== 8'd1 || a_miss !== 1'b0) begin
      n_err++; $display("FAIL hit_pulse got h=%b sc=%0d m=%b want 1/1/0", a_hit, a_score, a_miss);
    end
    @(negedge clk);
    n_cmp++; if (a_hit !== 1'b0) begin n_err++; $display("FAIL hit_width got %b want 0", a_hit); end
    tick_a(1);
    n_cmp++; if (a_y1 !== 12'd402 || a_x1 !== 12'd606 || a_score !== 8'd1) begin
      n_err++; $display("FAIL after_hit got x1=%0d y1=%0d sc=%0d want 606/402/1", a_x1, a_y1, a_score);
    end
  endtask

  task automatic test_reset_mid_play();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++; if (a_state !== 2'd0 || a_score !== 8'd0 || a_x1 !== 12'd312 || a_y1 !== 12'd112 || a_hit !== 1'b0 || a_miss !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got st=%0d sc=%0d x1=%0d y1=%0d h=%b m=%b", a_state, a_score, a_x1, a_y1, a_hit, a_miss);
    end
  endtask

  task automatic test_corner_saturate();
    n_cmp++; if (b_x1 !== 12'd12 || b_y1 !== 12'd12 || b_state !== 2'd0) begin
      n_err++; $display("FAIL b_reset got x1=%0d y1=%0d st=%0d want 12/12/0", b_x1, b_y1, b_state);
    end
    tick_b(5);
    n_cmp++; if (b_x1 !== 12'd22 || b_y1 !== 12'd22 || b_state !== 2'd1) begin
      n_err++; $display("FAIL b_pre_hit got x1=%0d y1=%0d st=%0d want 22/22/1", b_x1, b_y1, b_state);
    end
    tick_b(1);
    n_cmp++; if (b_x1 !== 12'd24 || b_y1 !== 12'd24 || b_hit !== 1'b1 || b_miss !== 1'b0 || b_score !== 8'd1) begin
      n_err++; $display("FAIL b_hit_over_floor got x1=%0d y1=%0d h=%b m=%b sc=%0d", b_x1, b_y1, b_hit, b_miss, b_score);
    end
    tick_b(12);
    n_cmp++; if (b_x1 !== 12'd0 || b_y1 !== 12'd0) begin n_err++; $display("FAIL b_pre_corner got x1=%0d y1=%0d want 0/0", b_x1, b_y1); end
    tick_b(1);
    n_cmp++; if (b_x1 !== 12'd0 || b_y1 !== 12'd0) begin n_err++; $display("FAIL b_corner got x1=%0d y1=%0d want 0/0", b_x1, b_y1); end
    tick_b(1);
    n_cmp++; if (b_x1 !== 12'd2 || b_y1 !== 12'd2 || b_x2 !== 12'd18) begin
      n_err++; $display("FAIL b_post_corner got x1=%0d y1=%0d x2=%0d want 2/2/18", b_x1, b_y1, b_x2);
    end
    tick_b(6335);
    n_cmp++; if (b_score !== 8'd254) begin n_err++; $display("FAIL b_score_254 got %0d want 254", b_score); end
    tick_b(1);
    n_cmp++; if (b_score !== 8'd255 || b_hit !== 1'b1) begin n_err++; $display("FAIL b_score_255 got sc=%0d h=%b want 255/1", b_score, b_hit); end
    tick_b(1124);
    n_cmp++; if (b_score !== 8'd255 || b_state !== 2'd1) begin n_err++; $display("FAIL b_pre_300 got sc=%0d st=%0d want 255/1", b_score, b_state); end
    tick_b(1);
    n_cmp++; if (b_score !== 8'd255 || b_hit !== 1'b1 || b_x1 !== 12'd24 || b_y1 !== 12'd24) begin
      n_err++; $display("FAIL b_hit_300 got sc=%0d h=%b x1=%0d y1=%0d want 255/1/24/24", b_score, b_hit, b_x1, b_y1);
    end
  endtask

  initial begin
    test_reset();
    test_serve_freeze();
    test_right_wall();
    test_floor_miss();
    test_paddle_hit();
    test_reset_mid_play();
    test_corner_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
